// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing source with a colour-return path aligned to hsync/vsync.
// Optional: define VGA_TEST_PATTERN_EN to replace RGBIn with internal colour bars.
module vga_timing_gen #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int RGB_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pixelEn,
    input  logic [7:0]  RGBIn,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    output logic        hSyncN,
    output logic        vSyncN,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_END_ACT  = 11'(H_VISIBLE - 1);
    localparam logic [10:0] H_END_FP   = 11'(H_VISIBLE + H_FRONT - 1);
    localparam logic [10:0] H_END_SYNC = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_END_ACT  = 11'(V_VISIBLE - 1);
    localparam logic [10:0] V_END_FP   = 11'(V_VISIBLE + V_FRONT - 1);
    localparam logic [10:0] V_END_SYNC = 11'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);

    localparam logic [1:0] H_ACTIVE  = 2'd0;
    localparam logic [1:0] H_FRONT_P = 2'd1;
    localparam logic [1:0] H_SYNC_P  = 2'd2;
    localparam logic [1:0] H_BACK_P  = 2'd3;
    localparam logic [1:0] V_ACTIVE  = 2'd0;
    localparam logic [1:0] V_FRONT_P = 2'd1;
    localparam logic [1:0] V_SYNC_P  = 2'd2;
    localparam logic [1:0] V_BACK_P  = 2'd3;

    logic [1:0] h_state, h_next;
    logic [1:0] v_state, v_next;
    logic       line_end, frame_last_line;
    logic       hs_raw, vs_raw, visible;
    logic       at_origin, origin_q;
    logic [7:0] pix_rgb;

    logic [RGB_LATENCY:0]   hs_pipe;
    logic [RGB_LATENCY:0]   vs_pipe;
    logic [RGB_LATENCY-1:0] vis_pipe;

    assign line_end        = (pixelX == H_LAST);
    assign frame_last_line = (pixelY == V_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            pixelX <= '0;
            pixelY <= '0;
        end else if (pixelEn) begin
            if (line_end) begin
                pixelX <= '0;
                pixelY <= frame_last_line ? 11'd0 : pixelY + 11'd1;
            end else begin
                pixelX <= pixelX + 11'd1;
            end
        end
    end

    // State registers move with the counters, so each state always describes the current pixelX/pixelY
    always_comb begin
        h_next = h_state;
        case (h_state)
            H_ACTIVE:  if (pixelX == H_END_ACT)  h_next = H_FRONT_P;
            H_FRONT_P: if (pixelX == H_END_FP)   h_next = H_SYNC_P;
            H_SYNC_P:  if (pixelX == H_END_SYNC) h_next = H_BACK_P;
            H_BACK_P:  if (line_end)             h_next = H_ACTIVE;
            default:                             h_next = H_ACTIVE;
        endcase
    end

    always_comb begin
        v_next = v_state;
        if (line_end) begin
            case (v_state)
                V_ACTIVE:  if (pixelY == V_END_ACT)  v_next = V_FRONT_P;
                V_FRONT_P: if (pixelY == V_END_FP)   v_next = V_SYNC_P;
                V_SYNC_P:  if (pixelY == V_END_SYNC) v_next = V_BACK_P;
                V_BACK_P:  if (frame_last_line)      v_next = V_ACTIVE;
                default:                             v_next = V_ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_state <= H_ACTIVE;
            v_state <= V_ACTIVE;
        end else if (pixelEn) begin
            h_state <= h_next;
            v_state <= v_next;
        end
    end

    assign hs_raw  = (h_state != H_SYNC_P);
    assign vs_raw  = (v_state != V_SYNC_P);
    assign visible = (pixelX < 11'(H_VISIBLE)) && (pixelY < 11'(V_VISIBLE));

    // Edge-detect on the origin so a stall parked at (0,0) yields a single pulse
    assign at_origin = (pixelX == 11'd0) && (pixelY == 11'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            origin_q     <= 1'b0;
            startOfFrame <= 1'b0;
        end else begin
            origin_q     <= at_origin;
            startOfFrame <= at_origin && !origin_q;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [RGB_LATENCY-1:0][10:0] x_pipe;

    function automatic logic [7:0] bar_color(input logic [10:0] x);
        if      (x < 11'd80)  return 8'hFF;
        else if (x < 11'd160) return 8'hFC;
        else if (x < 11'd240) return 8'h1F;
        else if (x < 11'd320) return 8'h1C;
        else if (x < 11'd400) return 8'hE3;
        else if (x < 11'd480) return 8'hE0;
        else if (x < 11'd560) return 8'h03;
        else                  return 8'h00;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            x_pipe <= '0;
        end else if (pixelEn) begin
            x_pipe[0] <= pixelX;
            for (int i = 1; i < RGB_LATENCY; i++) x_pipe[i] <= x_pipe[i-1];
        end
    end

    assign pix_rgb = bar_color(x_pipe[RGB_LATENCY-1]);
`else
    assign pix_rgb = RGBIn;
`endif

    // The colour register is the final stage of the visible pipe; sync pipes carry one extra stage to match
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_pipe  <= '1;
            vs_pipe  <= '1;
            vis_pipe <= '0;
            red      <= '0;
            green    <= '0;
            blue     <= '0;
        end else if (pixelEn) begin
            hs_pipe[0]  <= hs_raw;
            vs_pipe[0]  <= vs_raw;
            vis_pipe[0] <= visible;
            for (int i = 1; i <= RGB_LATENCY; i++) begin
                hs_pipe[i] <= hs_pipe[i-1];
                vs_pipe[i] <= vs_pipe[i-1];
            end
            for (int i = 1; i < RGB_LATENCY; i++) vis_pipe[i] <= vis_pipe[i-1];
            if (vis_pipe[RGB_LATENCY-1]) begin
                red   <= {pix_rgb[7:5], pix_rgb[7]};
                green <= {pix_rgb[4:2], pix_rgb[4]};
                blue  <= {pix_rgb[1:0], pix_rgb[1:0]};
            end else begin
                red   <= '0;
                green <= '0;
                blue  <= '0;
            end
        end
    end

    assign hSyncN = hs_pipe[RGB_LATENCY];
    assign vSyncN = vs_pipe[RGB_LATENCY];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size 640x480 instance for line timing and colour, plus a
// shrunken-raster instance (15x13, latency 2) so frame wrap and vsync fit a short run.
module tb_vga_timing_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        pixelEn;
    logic [7:0]  RGBIn;

    logic [10:0] pixelX, pixelY;
    logic        startOfFrame, hSyncN, vSyncN;
    logic [3:0]  red, green, blue;

    logic [10:0] s_x, s_y;
    logic        s_sof, s_hs, s_vs;
    logic [3:0]  s_r, s_g, s_b;

    int n_cmp = 0;
    int n_err = 0;
    bit done  = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen u_dut (
        .clk(clk), .reset(reset), .pixelEn(pixelEn), .RGBIn(RGBIn),
        .pixelX(pixelX), .pixelY(pixelY), .startOfFrame(startOfFrame),
        .hSyncN(hSyncN), .vSyncN(vSyncN), .red(red), .green(green), .blue(blue)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .RGB_LATENCY(2)
    ) u_small (
        .clk(clk), .reset(reset), .pixelEn(pixelEn), .RGBIn(RGBIn),
        .pixelX(s_x), .pixelY(s_y), .startOfFrame(s_sof),
        .hSyncN(s_hs), .vSyncN(s_vs), .red(s_r), .green(s_g), .blue(s_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #1ms;
        if (!done) begin
            n_err++;
            $error("FAIL watchdog: sequence did not complete in time");
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
            $finish;
        end
    end

    initial begin
        int  fall_cnt, fall1_t, fall1_x, fall2_t, low_run, sof_cnt, vs_low;
        logic prev_hs;

        reset = 1'b1; pixelEn = 1'b1; RGBIn = 8'hFF;
        step(3);
        chk("rst_x", pixelX, 11'd0);
        chk("rst_y", pixelY, 11'd0);
        chk("rst_hs", hSyncN, 1'b1);
        chk("rst_vs", vSyncN, 1'b1);
        chk("rst_red", red, 4'h0);
        chk("rst_green", green, 4'h0);
        chk("rst_blue", blue, 4'h0);
        chk("rst_sof", startOfFrame, 1'b0);
        chk("rst_small_y", s_y, 11'd0);

        reset = 1'b0;
        fall_cnt = 0; fall1_t = 0; fall1_x = 0; fall2_t = 0; low_run = 0; prev_hs = 1'b1;
        for (int t = 1; t <= 1700; t++) begin
            tick();
            if (prev_hs && !hSyncN) begin
                if (fall_cnt == 0) begin fall1_t = t; fall1_x = int'(pixelX); end
                else if (fall_cnt == 1) fall2_t = t;
                fall_cnt++;
            end
            if (fall_cnt == 1 && !hSyncN) low_run++;
            prev_hs = hSyncN;
            if (pixelY == 11'd0 && pixelX == 11'd2) begin
                chk("vis_first_red", red, 4'hF);
                chk("vis_first_blue", blue, 4'hF);
            end
`ifndef VGA_TEST_PATTERN_EN
            if (pixelY == 11'd0 && pixelX == 11'd641) chk("vis_last_green", green, 4'hF);
`endif
            if (pixelY == 11'd0 && pixelX == 11'd642) begin
                chk("blank_red", red, 4'h0);
                chk("blank_green", green, 4'h0);
                chk("blank_blue", blue, 4'h0);
            end
            if (pixelY == 11'd1 && pixelX == 11'd0) chk("blank_porch_red", red, 4'h0);
        end
        chk("hs_fall_count", fall_cnt, 2);
        chk("hs_first_low_x", fall1_x, 658);
        chk("hs_low_width", low_run, 96);
        chk("hs_period", fall2_t - fall1_t, 800);

`ifndef VGA_TEST_PATTERN_EN
        RGBIn = 8'hA6;
        step(3);
        chk("exp_a6_red", red, 4'hB);
        chk("exp_a6_green", green, 4'h2);
        chk("exp_a6_blue", blue, 4'hA);
`endif

        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst2_small_x", s_x, 11'd0);
        sof_cnt = 0; vs_low = 0;
        for (int t = 1; t <= 400; t++) begin
            tick();
            if (t == 194) begin
                chk("wrap_pre_x", s_x, 11'd14);
                chk("wrap_pre_y", s_y, 11'd12);
            end
            if (t == 195) begin
                chk("wrap_x", s_x, 11'd0);
                chk("wrap_y", s_y, 11'd0);
                chk("wrap_sof_early", s_sof, 1'b0);
            end
            if (t == 196) chk("wrap_sof", s_sof, 1'b1);
            if (t == 122) chk("vs_before", s_vs, 1'b1);
            if (t == 123) chk("vs_first_low", s_vs, 1'b0);
            if (t == 152) chk("vs_last_low", s_vs, 1'b0);
            if (t == 153) chk("vs_after", s_vs, 1'b1);
            if (t >= 2 && s_sof) sof_cnt++;
            if (t >= 11 && t <= 205 && !s_vs) vs_low++;
        end
        chk("sof_pulses", sof_cnt, 2);
        chk("vs_low_per_frame", vs_low, 30);

        reset = 1'b1; tick(); reset = 1'b0;
        step(195);
        chk("stall_origin_x", s_x, 11'd0);
        chk("stall_origin_sof0", s_sof, 1'b0);
        pixelEn = 1'b0;
        tick();
        chk("stall_sof_once", s_sof, 1'b1);
        tick();
        chk("stall_sof_no_repeat", s_sof, 1'b0);
        chk("stall_hold_y", s_y, 11'd0);
        chk("stall_hold_x", s_x, 11'd0);
        chk("stall_hold_bigx", pixelX, 11'd195);
        pixelEn = 1'b1;
        tick();
        chk("stall_resume_x", s_x, 11'd1);
        chk("stall_resume_sof", s_sof, 1'b0);
        chk("stall_resume_bigx", pixelX, 11'd196);

        step(461);
        chk("pre_hs_x", pixelX, 11'd657);
        chk("pre_hs", hSyncN, 1'b1);
        pixelEn = 1'b0;
        step(2);
        chk("hold_hs_x", pixelX, 11'd657);
        chk("hold_hs", hSyncN, 1'b1);
        chk("hold_red", red, 4'h0);
        pixelEn = 1'b1;
        tick();
        chk("post_hs_x", pixelX, 11'd658);
        chk("post_hs", hSyncN, 1'b0);

        step(67);
        chk("mid_y", s_y, 11'd9);
        chk("mid_x", s_x, 11'd5);
        chk("mid_vs_low", s_vs, 1'b0);
        reset = 1'b1; tick();
        chk("mid_rst_vs", s_vs, 1'b1);
        chk("mid_rst_y", s_y, 11'd0);
        chk("mid_rst_bigx", pixelX, 11'd0);
        reset = 1'b0; tick();
        chk("mid_rel_x", s_x, 11'd1);
        chk("mid_rel_vs", s_vs, 1'b1);
        chk("mid_rel_bigx", pixelX, 11'd1);

`ifdef VGA_TEST_PATTERN_EN
        RGBIn = 8'h00;
        tick();
        chk("pat_x0_red", red, 4'hF);
        chk("pat_x0_green", green, 4'hF);
        chk("pat_x0_blue", blue, 4'hF);
        step(400);
        chk("pat_x400_red", red, 4'hF);
        chk("pat_x400_green", green, 4'h0);
        chk("pat_x400_blue", blue, 4'h0);
        step(239);
        chk("pat_x639_red", red, 4'h0);
        chk("pat_x639_green", green, 4'h0);
        chk("pat_x639_blue", blue, 4'h0);
`else
        RGBIn = 8'h5C;
        step(3);
        chk("exp_5c_red", red, 4'h4);
        chk("exp_5c_green", green, 4'hF);
        chk("exp_5c_blue", blue, 4'h0);
        step(638);
        chk("exp_5c_blank_x", pixelX, 11'd642);
        chk("exp_5c_blank_green", green, 4'h0);
`endif

        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Source end of the pixel-coordinate interface used by every drawing block in the VGA path.
- Generates 640x480@60 raster timing and drives pixelX/pixelY to the drawing blocks.
- Takes back their merged 8-bit RGB (RRRGGGBB), blanks and expands it to 4-bit-per-channel DAC outputs.
- Delays hSync/vSync so they stay cycle-aligned with the returned pixel colour.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- RGB_LATENCY, 1, clocks from pixelX/pixelY to valid RGBIn (1..4)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pixelEn  in  1  pixel-rate tick; all timing advances only when high
- RGBIn  in  8  merged colour from drawing logic, RRRGGGBB
- pixelX  out  11  current horizontal count 0..H_TOTAL-1
- pixelY  out  11  current vertical count 0..V_TOTAL-1
- startOfFrame  out  1  one-clk pulse when the counters enter (0,0)
- hSyncN  out  1  active-low hsync, aligned with RGB outputs
- vSyncN  out  1  active-low vsync, aligned with RGB outputs
- red  out  4  DAC red
- green  out  4  DAC green
- blue  out  4  DAC blue

Behaviour:
- Derived totals: H_TOTAL = sum of the four H_* parameters (800); V_TOTAL = sum of the four V_* parameters (525).
- Reset (clk edge with reset=1):
  - pixelX, pixelY = 0.
  - startOfFrame = 0.
  - hSyncN, vSyncN = 1.
  - red, green, blue = 0.
  - Alignment pipeline is flushed to the blank/inactive state.
  - Reset mid-frame restarts the raster at (0,0) on the cycle after reset deasserts. No partial sync pulse is extended.
- Counters:
  - On a clk edge with pixelEn=1, pixelX increments.
  - At pixelX = H_TOTAL-1, pixelX wraps to 0 and pixelY increments.
  - At pixelY = V_TOTAL-1 with pixelX = H_TOTAL-1, both wrap to 0.
  - With pixelEn=0, all counters and pipeline stages hold.
- Horizontal FSM, tracking pixelX: H_ACTIVE -> H_FRONT_P -> H_SYNC_P -> H_BACK_P -> H_ACTIVE.
  - Transitions at pixelX = 639, 655, 751, 799 for default parameters.
  - The raw hsync term is low in H_SYNC_P (pixelX 656..751).
- Vertical FSM: V_ACTIVE -> V_FRONT_P -> V_SYNC_P -> V_BACK_P.
  - Advances only on line wrap.
  - The raw vsync term is low for pixelY 490..491.
- visible = (pixelX < H_VISIBLE) && (pixelY < V_VISIBLE).
- startOfFrame:
  - Asserted for exactly one clk, on the clk after the counters become (0,0).
  - Must not re-pulse while pixelEn=0 holds at (0,0).
- Alignment pipeline:
  - raw hsync, raw vsync and visible pass through a shift register of RGB_LATENCY+1 stages. Each stage is enabled by pixelEn.
  - RGBIn is sampled RGB_LATENCY pixel ticks after its coordinates, then registered once more.
  - Result: red/green/blue, hSyncN and vSyncN refer to the same pixel and appear RGB_LATENCY+1 pixel ticks after pixelX/pixelY.
- Colour expansion:
  - red = {R[2:0], R[2]}
  - green = {G[2:0], G[2]}
  - blue = {B[1:0], B[1:0]}
  - When the delayed visible = 0, red/green/blue are forced to 0 regardless of RGBIn.

Optional Feature:
- Macro VGA_TEST_PATTERN_EN.
- When defined:
  - RGBIn is ignored.
  - Colour is generated internally from the delayed pixelX as eight 80-pixel vertical bars, in this order: white FF, yellow FC, cyan 1F, green 1C, magenta E3, red E0, blue 03, black 00.
  - Same blanking and alignment rules apply.
- When undefined: RGBIn is used as specified and no pattern logic is synthesised.

Test Plan:
- Reset: hold reset=1 for 3 clks with pixelEn=1 -> pixelX=0, pixelY=0, hSyncN=1, vSyncN=1, red/green/blue=0, startOfFrame=0.
- Hsync timing: pixelEn=1 continuously, default parameters -> hSyncN low for exactly 96 consecutive ticks, first low at the tick when pixelX=658 (656 + 2 latency); period exactly 800 ticks.
- Frame wrap: run to pixelX=799, pixelY=524 -> next tick (0,0), single-clk startOfFrame; vSyncN low for 1600 ticks per frame.
- Blanking and expansion: RGBIn=FF constant -> red/green/blue=F during visible, 0 during pixelX 640..799. RGBIn=A6 (101_001_10) -> red=B, green=2, blue=A.
- Stall: pixelEn toggled 1-0-0-1 -> counters and all outputs hold across the zero ticks; no duplicate startOfFrame at (0,0); mid-frame reset at pixelY=200 restarts at (0,0).
- With VGA_TEST_PATTERN_EN defined: RGBIn=00 -> output colour at delayed pixelX=0 is F/F/F, at delayed pixelX=400 is F/0/0, and at pixelX=639 is 0/0/0.
